resp_misr_compactor: RTL and testbench
======================================

Name: resp_misr_compactor

Overview:
Downstream response stage for combinational CUT test (e.g. add2 with outputs N50/N51/N52).
- Consumes one CUT output vector per applied pattern over a valid/ready handshake.
- Compacts the vectors into a multiple-input signature register (MISR) and compares the final signature with a golden value.
- Replaces per-pattern file dumps with a single pass/fail result and signature for a test session.

Parameters:
WIDTH, 3, CUT output vector width; must satisfy 1 <= WIDTH <= SIG_W
SIG_W, 16, signature register width
POLY, 16'h1021, MISR feedback polynomial (Galois form, implicit x^SIG_W term)
SEED, 16'h0000, signature value loaded at session start
NUM_PATTERNS, 32, responses per session; must be >= 1
CNT_W, 16, pattern counter width; must satisfy 2^CNT_W > NUM_PATTERNS

Ports:
clk  input  1  rising-edge clock
rst  input  1  asynchronous reset, active-high
start  input  1  begin session; honoured in IDLE or DONE only
resp_valid  input  1  resp_data holds a valid CUT response
resp_data  input  WIDTH  CUT output vector; bit0 = first CUT output (N50)
resp_ready  output  1  stage accepts a response this cycle
golden_sig  input  SIG_W  expected signature; sampled at session end
busy  output  1  high in COMPACT
done  output  1  high in DONE
pass  output  1  signature == golden_sig; valid only while done=1
signature  output  SIG_W  current MISR contents
pat_count  output  CNT_W  responses accepted this session

Behaviour:
- Reset (async assert, sync release): state=IDLE; signature=SEED; pat_count=0; busy=0; done=0; pass=0; resp_ready=0.
- FSM states:
  - IDLE: start=1 -> COMPACT; signature<=SEED; pat_count<=0.
  - COMPACT: resp_ready=1, driven combinationally from state only and never from resp_valid. A handshake (resp_valid & resp_ready) updates the MISR and increments pat_count. The handshake that makes pat_count == NUM_PATTERNS -> DONE; pass<=(next signature == golden_sig) in the same edge.
  - DONE: done=1, signature and pass held; start=1 -> COMPACT with re-seed and pat_count<=0 (back-to-back sessions, no IDLE cycle).
- MISR step on handshake:
  - sig_next = (sig << 1) ^ (sig[SIG_W-1] ? POLY : 0) ^ zext(resp_data).
  - One update per handshake; no update without a handshake.
- Latency: signature reflects a response one cycle after its handshake. done and pass assert one cycle after the final handshake.
- Ignored events:
  - resp_valid outside COMPACT has no effect (resp_ready=0).
  - start in COMPACT has no effect; sessions cannot be aborted except by rst.
- Stalls: resp_valid low for any number of cycles in COMPACT freezes signature and pat_count.
- golden_sig may change freely during COMPACT; only the value at the final handshake matters.
- rst mid-session discards all state; the next session requires a new start.
- pat_count never wraps within a session (guaranteed by CNT_W rule).

Decomposition:
- Shared package dft_bist_pkg: FSM state enum (S_IDLE, S_COMPACT, S_DONE); default MISR polynomial and seed constants shared with the upstream LFSR pattern generator.
- One sub-module, misr_reg: holds the signature register and the step function. Ports: clk, rst, load_seed, shift_en, data_in; output sig. The top owns the FSM, counter and compare.

Test Plan:
1. Reset then idle: assert rst mid-cycle, hold resp_valid=1 -> all outputs at reset values immediately; resp_ready=0; signature=0x0000.
2. NUM_PATTERNS=2, SEED=0, golden=0x0009: start, send 3'b101 then 3'b011 -> signature 0x0005 then 0x0009; done=1 with pass=1 one cycle after the 2nd handshake; pat_count=2.
3. Feedback tap: SEED=16'h8000, NUM_PATTERNS=1, data 3'b000, golden=0x1021 -> signature=0x1021, pass=1. Repeat with golden=0x1020 -> pass=0.
4. Stalls: NUM_PATTERNS=2, valid gapped 5 idle cycles between the two responses of scenario 2 -> identical final signature 0x0009; pat_count held during the gap.
5. Default config, all-zero responses, 32 patterns, golden=0 -> pass=1. Then start in DONE -> busy=1 next cycle; signature=SEED; pat_count=0. start pulsed during COMPACT changes nothing.
6. Reset mid-session: rst after 10 of 32 handshakes -> IDLE, pat_count=0. Further resp_valid is ignored until start.

Source files
------------

// File: rtl/dft_bist_pkg.sv
// rtl/dft_bist_pkg.sv - shared DFT/BIST types and default MISR constants
// Shared with the upstream LFSR pattern generator so both ends agree on polynomial/seed.
package dft_bist_pkg;

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_COMPACT = 2'd1,
    S_DONE    = 2'd2
  } bist_state_t;

  localparam int          MISR_SIG_W        = 16;
  localparam logic [15:0] MISR_POLY_DEFAULT = 16'h1021;
  localparam logic [15:0] MISR_SEED_DEFAULT = 16'h0000;

endpackage

// File: rtl/resp_misr_compactor_if.sv
// rtl/resp_misr_compactor_if.sv - CUT response valid/ready channel
// Master is the pattern applicator side; slave is the compactor.
interface resp_misr_compactor_if #(
  parameter int WIDTH = 3
) ();

  logic             resp_valid;
  logic [WIDTH-1:0] resp_data;
  logic             resp_ready;

  modport master (
    output resp_valid,
    output resp_data,
    input  resp_ready
  );

  modport slave (
    input  resp_valid,
    input  resp_data,
    output resp_ready
  );

endinterface

// File: rtl/misr_reg.sv
// rtl/misr_reg.sv - multiple-input signature register (Galois form)
// load_seed wins over shift_en so a restart never folds in a stray response.
module misr_reg
  import dft_bist_pkg::*;
#(
  parameter int               WIDTH = 3,
  parameter int               SIG_W = MISR_SIG_W,
  parameter logic [SIG_W-1:0] POLY  = MISR_POLY_DEFAULT,
  parameter logic [SIG_W-1:0] SEED  = MISR_SEED_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load_seed,
  input  logic             shift_en,
  input  logic [WIDTH-1:0] data_in,
  output logic [SIG_W-1:0] sig
);

  logic [SIG_W-1:0] sig_q;
  logic [SIG_W-1:0] sig_step;
  logic [SIG_W-1:0] feedback;

  always_comb begin
    feedback = sig_q[SIG_W-1] ? POLY : '0;
    sig_step = (sig_q << 1) ^ feedback ^ SIG_W'(data_in);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sig_q <= SEED;
    end else if (load_seed) begin
      sig_q <= SEED;
    end else if (shift_en) begin
      sig_q <= sig_step;
    end
  end

  assign sig = sig_q;

endmodule

// File: rtl/resp_misr_compactor.sv
// rtl/resp_misr_compactor.sv - response compaction stage with golden signature compare
// Owns the session FSM, pattern counter and the end-of-session compare.
module resp_misr_compactor
  import dft_bist_pkg::*;
#(
  parameter int               WIDTH        = 3,
  parameter int               SIG_W        = MISR_SIG_W,
  parameter logic [SIG_W-1:0] POLY         = MISR_POLY_DEFAULT,
  parameter logic [SIG_W-1:0] SEED         = MISR_SEED_DEFAULT,
  parameter int               NUM_PATTERNS = 32,
  parameter int               CNT_W        = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  resp_misr_compactor_if.slave   resp,
  input  logic [SIG_W-1:0]       golden_sig,
  output logic                   busy,
  output logic                   done,
  output logic                   pass,
  output logic [SIG_W-1:0]       signature,
  output logic [CNT_W-1:0]       pat_count
);

  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_PATTERNS - 1);

  bist_state_t      state_q;
  bist_state_t      state_d;
  logic             session_start;
  logic             handshake;
  logic             last_handshake;
  logic             ready;
  logic [CNT_W-1:0] count_q;
  logic [SIG_W-1:0] golden_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ready depends on state only so the upstream handshake never forms a comb loop.
  always_comb begin
    state_d       = state_q;
    ready         = 1'b0;
    busy          = 1'b0;
    done          = 1'b0;
    session_start = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          session_start = 1'b1;
          state_d       = S_COMPACT;
        end
      end
      S_COMPACT: begin
        ready = 1'b1;
        busy  = 1'b1;
        if (last_handshake) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        done = 1'b1;
        if (start) begin
          session_start = 1'b1;
          state_d       = S_COMPACT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign handshake      = resp.resp_valid & ready;
  assign last_handshake = handshake && (count_q == LAST_CNT);
  assign resp.resp_ready = ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
    end else if (session_start) begin
      count_q <= '0;
    end else if (handshake) begin
      count_q <= count_q + 1'b1;
    end
  end

  // Golden value is captured at the final handshake; later changes are ignored.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      golden_q <= '0;
    end else if (last_handshake) begin
      golden_q <= golden_sig;
    end
  end

  misr_reg #(
    .WIDTH (WIDTH),
    .SIG_W (SIG_W),
    .POLY  (POLY),
    .SEED  (SEED)
  ) u_misr (
    .clk       (clk),
    .rst       (rst),
    .load_seed (session_start),
    .shift_en  (handshake),
    .data_in   (resp.resp_data),
    .sig       (signature)
  );

  // Signature is frozen in DONE, so comparing against the captured golden is stable.
  assign pass      = done && (signature == golden_q);
  assign pat_count = count_q;

endmodule

// File: tb/tb_resp_misr_compactor.sv
// tb/tb_resp_misr_compactor.sv - directed self-checking bench for resp_misr_compactor
// Three instances cover the NUM_PATTERNS=2, feedback-tap and default configurations.
module tb_resp_misr_compactor;

  logic clk;
  logic rst;
  logic start_a, start_b, start_c;
  logic [15:0] golden_a, golden_b, golden_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic pass_a, pass_b, pass_c;
  logic [15:0] sig_a, sig_b, sig_c;
  logic [15:0] cnt_a, cnt_b, cnt_c;

  int checks = 0;
  int errors = 0;

  resp_misr_compactor_if #(.WIDTH(3)) if_a ();
  resp_misr_compactor_if #(.WIDTH(3)) if_b ();
  resp_misr_compactor_if #(.WIDTH(3)) if_c ();

  resp_misr_compactor #(.NUM_PATTERNS(2), .SEED(16'h0000)) dut_a (
    .clk(clk), .rst(rst), .start(start_a), .resp(if_a.slave), .golden_sig(golden_a),
    .busy(busy_a), .done(done_a), .pass(pass_a), .signature(sig_a), .pat_count(cnt_a)
  );

  resp_misr_compactor #(.NUM_PATTERNS(1), .SEED(16'h8000)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .resp(if_b.slave), .golden_sig(golden_b),
    .busy(busy_b), .done(done_b), .pass(pass_b), .signature(sig_b), .pat_count(cnt_b)
  );

  resp_misr_compactor dut_c (
    .clk(clk), .rst(rst), .start(start_c), .resp(if_c.slave), .golden_sig(golden_c),
    .busy(busy_c), .done(done_c), .pass(pass_c), .signature(sig_c), .pat_count(cnt_c)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b0;
    start_a = 1'b0; start_b = 1'b0; start_c = 1'b0;
    golden_a = 16'h0009; golden_b = 16'h1021; golden_c = 16'h0000;
    if_a.resp_valid = 1'b1; if_a.resp_data = 3'b111;
    if_b.resp_valid = 1'b1; if_b.resp_data = 3'b111;
    if_c.resp_valid = 1'b1; if_c.resp_data = 3'b111;

    // 1: async reset mid-cycle with valid held high
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("rst_busy", busy_a, 1'b0);
    check("rst_done", done_a, 1'b0);
    check("rst_pass", pass_a, 1'b0);
    check("rst_ready", if_a.resp_ready, 1'b0);
    check("rst_sig", sig_a, 16'h0000);
    check("rst_cnt", cnt_a, 16'h0000);
    check("rst_sig_b", sig_b, 16'h8000);
    @(negedge clk);
    rst = 1'b0;
    cycle();
    check("idle_ignore_cnt", cnt_a, 16'h0000);
    check("idle_ignore_sig", sig_a, 16'h0000);
    check("idle_ready", if_a.resp_ready, 1'b0);
    if_a.resp_valid = 1'b0; if_b.resp_valid = 1'b0; if_c.resp_valid = 1'b0;

    // 2: two patterns, 101 then 011
    start_a = 1'b1; cycle(); start_a = 1'b0;
    check("s2_busy", busy_a, 1'b1);
    check("s2_ready", if_a.resp_ready, 1'b1);
    check("s2_seed", sig_a, 16'h0000);
    if_a.resp_valid = 1'b1; if_a.resp_data = 3'b101;
    cycle();
    check("s2_sig1", sig_a, 16'h0005);
    check("s2_cnt1", cnt_a, 16'd1);
    check("s2_done_early", done_a, 1'b0);
    if_a.resp_data = 3'b011;
    cycle();
    if_a.resp_valid = 1'b0;
    check("s2_sig2", sig_a, 16'h0009);
    check("s2_done", done_a, 1'b1);
    check("s2_pass", pass_a, 1'b1);
    check("s2_cnt2", cnt_a, 16'd2);
    check("s2_busy_off", busy_a, 1'b0);
    check("s2_ready_off", if_a.resp_ready, 1'b0);
    cycle();
    check("s2_hold_sig", sig_a, 16'h0009);
    check("s2_hold_pass", pass_a, 1'b1);

    // 4: restart from DONE, 5-cycle stall, golden wiggled mid-session
    start_a = 1'b1; cycle(); start_a = 1'b0;
    check("s4_busy", busy_a, 1'b1);
    check("s4_reseed", sig_a, 16'h0000);
    check("s4_cnt0", cnt_a, 16'd0);
    if_a.resp_valid = 1'b1; if_a.resp_data = 3'b101;
    cycle();
    if_a.resp_valid = 1'b0;
    golden_a = 16'h0000;
    repeat (5) cycle();
    check("s4_gap_cnt", cnt_a, 16'd1);
    check("s4_gap_sig", sig_a, 16'h0005);
    check("s4_gap_done", done_a, 1'b0);
    golden_a = 16'h0009;
    if_a.resp_valid = 1'b1; if_a.resp_data = 3'b011;
    cycle();
    if_a.resp_valid = 1'b0;
    golden_a = 16'h1234;
    check("s4_sig", sig_a, 16'h0009);
    check("s4_pass", pass_a, 1'b1);
    check("s4_cnt", cnt_a, 16'd2);

    // 3: feedback tap from MSB of seed
    start_b = 1'b1; cycle(); start_b = 1'b0;
    check("s3_seed", sig_b, 16'h8000);
    if_b.resp_valid = 1'b1; if_b.resp_data = 3'b000;
    cycle();
    if_b.resp_valid = 1'b0;
    check("s3_sig", sig_b, 16'h1021);
    check("s3_done", done_b, 1'b1);
    check("s3_pass", pass_b, 1'b1);
    golden_b = 16'h1020;
    start_b = 1'b1; cycle(); start_b = 1'b0;
    check("s3b_seed", sig_b, 16'h8000);
    check("s3b_busy", busy_b, 1'b1);
    if_b.resp_valid = 1'b1;
    cycle();
    if_b.resp_valid = 1'b0;
    check("s3b_sig", sig_b, 16'h1021);
    check("s3b_done", done_b, 1'b1);
    check("s3b_pass", pass_b, 1'b0);

    // 5: default config, 32 zero responses, start pulsed mid-session
    start_c = 1'b1; cycle(); start_c = 1'b0;
    if_c.resp_valid = 1'b1; if_c.resp_data = 3'b000;
    for (int i = 0; i < 32; i++) begin
      if (i == 15) start_c = 1'b1;
      cycle();
      start_c = 1'b0;
      if (i == 15) begin
        check("s5_start_ignored_busy", busy_c, 1'b1);
        check("s5_start_ignored_cnt", cnt_c, 16'd16);
      end
    end
    if_c.resp_valid = 1'b0;
    check("s5_done", done_c, 1'b1);
    check("s5_pass", pass_c, 1'b1);
    check("s5_sig", sig_c, 16'h0000);
    check("s5_cnt", cnt_c, 16'd32);
    start_c = 1'b1; cycle(); start_c = 1'b0;
    check("s5_restart_busy", busy_c, 1'b1);
    check("s5_restart_done", done_c, 1'b0);
    check("s5_restart_cnt", cnt_c, 16'd0);
    check("s5_restart_sig", sig_c, 16'h0000);

    // 6: reset after 10 handshakes, then valid ignored in IDLE
    if_c.resp_valid = 1'b1;
    repeat (10) cycle();
    check("s6_cnt10", cnt_c, 16'd10);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    check("s6_rst_busy", busy_c, 1'b0);
    check("s6_rst_cnt", cnt_c, 16'd0);
    check("s6_rst_ready", if_c.resp_ready, 1'b0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) cycle();
    check("s6_idle_cnt", cnt_c, 16'd0);
    check("s6_idle_busy", busy_c, 1'b0);
    check("s6_idle_done", done_c, 1'b0);
    check("s6_idle_a_sig", sig_a, 16'h0000);
    if_c.resp_valid = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
